// File: rtl/integral_image_engine.sv
// Integral-image (summed-area table) engine: walks the frame row-major, one pixel per RD_LAT+3 cycles.
// Optional saturation enabled by defining INTEGRAL_SAT_EN; otherwise sums wrap and sat_flag is 0.
module integral_image_engine #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int PIX_W  = 8,
    parameter int SUM_W  = 25,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [PIX_W-1:0]  src_rd_data,
    output logic [ADDR_W-1:0] int_rd_addr,
    input  logic [SUM_W-1:0]  int_rd_data,
    output logic [ADDR_W-1:0] int_wr_addr,
    output logic [SUM_W-1:0]  int_wr_data,
    output logic              int_wr_en,
    output logic              sat_flag
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IMG_H - 1);
    localparam logic [1:0]        LAST_WAIT  = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [SUM_W-1:0]  row_acc;
    logic [1:0]        wait_cnt;
    logic              last_pixel;
    logic              accept;
    logic [SUM_W-1:0]  above;
    logic [SUM_W-1:0]  acc_next;
    logic [SUM_W-1:0]  sum_next;

    assign last_pixel = (row == LAST_ROW) && (col == LAST_COL);
    assign accept     = (state == IDLE) && start;
    assign above      = (row != '0) ? int_rd_data : '0;

`ifdef INTEGRAL_SAT_EN
    localparam int EXT_W = SUM_W + 2;
    localparam logic [EXT_W-1:0] SUM_MAX = EXT_W'({SUM_W{1'b1}});

    logic [EXT_W-1:0] acc_ext;
    logic [EXT_W-1:0] sum_ext;

    // Extra headroom bits let us see any carry out before clamping
    always_comb begin
        acc_ext  = EXT_W'(row_acc) + EXT_W'(src_rd_data);
        sum_ext  = acc_ext + EXT_W'(above);
        acc_next = (acc_ext > SUM_MAX) ? '1 : acc_ext[SUM_W-1:0];
        sum_next = (sum_ext > SUM_MAX) ? '1 : sum_ext[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || accept)
            sat_flag <= 1'b0;
        else if (state == ACC && sum_ext > SUM_MAX)
            sat_flag <= 1'b1;
    end
`else
    always_comb begin
        acc_next = row_acc + SUM_W'(src_rd_data);
        sum_next = acc_next + above;
    end

    assign sat_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        int_wr_en = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = REQ;
            REQ:   begin busy = 1'b1; state_nxt = WAIT; end
            WAIT:  begin busy = 1'b1; if (wait_cnt == LAST_WAIT) state_nxt = ACC; end
            ACC:   begin busy = 1'b1; state_nxt = WRITE; end
            WRITE: begin
                busy      = 1'b1;
                int_wr_en = 1'b1;
                state_nxt = last_pixel ? DONE : REQ;
            end
            DONE:  begin done = 1'b1; state_nxt = IDLE; end
            default: state_nxt = IDLE;
        endcase
    end

    // Read addresses are set up one cycle early so they are already valid during REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            row_acc     <= '0;
            wait_cnt    <= '0;
            src_rd_addr <= '0;
            int_rd_addr <= '0;
            int_wr_addr <= '0;
            int_wr_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    row         <= '0;
                    col         <= '0;
                    row_acc     <= '0;
                    src_rd_addr <= '0;
                end
                REQ:  wait_cnt <= '0;
                WAIT: wait_cnt <= wait_cnt + 2'd1;
                ACC: begin
                    row_acc     <= acc_next;
                    int_wr_data <= sum_next;
                    int_wr_addr <= src_rd_addr;
                end
                WRITE: if (!last_pixel) begin
                    src_rd_addr <= src_rd_addr + 1'b1;
                    if (row != '0 || col == LAST_COL)
                        int_rd_addr <= src_rd_addr + 1'b1 - ROW_STRIDE;
                    if (col == LAST_COL) begin
                        col     <= '0;
                        row     <= row + 1'b1;
                        row_acc <= '0;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_integral_image_engine.sv
// Self-checking bench for integral_image_engine: behavioural memories plus a direct-summation reference model.
// Expectations follow INTEGRAL_SAT_EN when it is defined for the build.
module tb_integral_image_engine;

    localparam int IMG_W     = 4;
    localparam int IMG_H     = 4;
    localparam int PIX_W     = 8;
    localparam int SUM_W     = 9;
    localparam int ADDR_W    = 8;
    localparam int RD_LAT    = 2;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int PIX_CYC   = RD_LAT + 3;
    localparam int FRAME_CYC = NPIX * PIX_CYC + 1;
    localparam int SUM_MAX   = (1 << SUM_W) - 1;
    localparam int LOG_N     = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [PIX_W-1:0]  src_rd_data;
    logic [ADDR_W-1:0] int_rd_addr;
    logic [SUM_W-1:0]  int_rd_data;
    logic [ADDR_W-1:0] int_wr_addr;
    logic [SUM_W-1:0]  int_wr_data;
    logic              int_wr_en;
    logic              sat_flag;

    int errors = 0;
    int checks = 0;

    integral_image_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
        .SUM_W(SUM_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .int_rd_addr(int_rd_addr), .int_rd_data(int_rd_data),
        .int_wr_addr(int_wr_addr), .int_wr_data(int_wr_data),
        .int_wr_en(int_wr_en), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    logic [PIX_W-1:0]  src_mem[NPIX];
    logic [SUM_W-1:0]  int_mem[NPIX];
    logic [ADDR_W-1:0] src_pipe[RD_LAT];
    logic [ADDR_W-1:0] int_pipe[RD_LAT];
    logic [ADDR_W-1:0] log_addr[LOG_N];
    logic [SUM_W-1:0]  log_data[LOG_N];
    int                log_time[LOG_N];
    int                cyc = 0;
    int                wr_count = 0;
    int                bad_wr = 0;
    int                bad_rd = 0;

    logic [SUM_W-1:0]  exp_val[NPIX];
    logic              exp_sat;

    assign src_rd_data = (int'(src_pipe[RD_LAT-1]) < NPIX) ? src_mem[int'(src_pipe[RD_LAT-1])] : '0;
    assign int_rd_data = (int'(int_pipe[RD_LAT-1]) < NPIX) ? int_mem[int'(int_pipe[RD_LAT-1])] : '0;

    // Memories with RD_LAT cycles of read latency, plus a log of every integral write
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        src_pipe[0] <= src_rd_addr;
        int_pipe[0] <= int_rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            src_pipe[i] <= src_pipe[i-1];
            int_pipe[i] <= int_pipe[i-1];
        end
        if (int_wr_en) begin
            log_addr[wr_count % LOG_N] <= int_wr_addr;
            log_data[wr_count % LOG_N] <= int_wr_data;
            log_time[wr_count % LOG_N] <= cyc;
            wr_count <= wr_count + 1;
            if (int'(int_wr_addr) < NPIX) int_mem[int'(int_wr_addr)] <= int_wr_data;
            else bad_wr <= bad_wr + 1;
        end
        if (busy && (int'(src_rd_addr) >= NPIX || int'(int_rd_addr) >= NPIX))
            bad_rd <= bad_rd + 1;
    end

    // Reference: I(r,c) by direct rectangle summation, then wrap or clamp
    function automatic void compute_model();
        exp_sat = 1'b0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                int unsigned s = 0;
                for (int rr = 0; rr <= r; rr++)
                    for (int cc = 0; cc <= c; cc++)
                        s += src_mem[rr*IMG_W + cc];
`ifdef INTEGRAL_SAT_EN
                if (s > SUM_MAX) begin
                    exp_val[r*IMG_W + c] = SUM_W'(SUM_MAX);
                    exp_sat = 1'b1;
                end else begin
                    exp_val[r*IMG_W + c] = SUM_W'(s);
                end
`else
                exp_val[r*IMG_W + c] = SUM_W'(s % (SUM_MAX + 1));
`endif
            end
        end
    endfunction

    task automatic load_pattern(input int kind);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0:       src_mem[i] = 8'd1;
                1:       src_mem[i] = PIX_W'(i);
                2:       src_mem[i] = 8'd255;
                3:       src_mem[i] = PIX_W'($urandom_range(0, 255));
                default: src_mem[i] = PIX_W'($urandom_range(0, 7));
            endcase
        end
        compute_model();
    endtask

    // Pulses (or holds) start, returns in the negedge of the done cycle
    task automatic run_frame(input bit hold_start, output int cycles, output bit timed_out,
                             output int busy_gaps, output logic done_busy);
        cycles = 0; timed_out = 1'b1; busy_gaps = 0; done_busy = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        while (cycles <= FRAME_CYC + 20) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                done_busy = busy;
                break;
            end
            if (!busy) busy_gaps++;
            @(posedge clk);
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks += 8;
        if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        if (done !== 1'b0)        begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        if (int_wr_en !== 1'b0)   begin errors++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", int_wr_en); end
        if (sat_flag !== 1'b0)    begin errors++; $display("[TB] FAIL reset_sat: got %0b expected 0", sat_flag); end
        if (src_rd_addr !== '0)   begin errors++; $display("[TB] FAIL reset_src_addr: got %0d expected 0", src_rd_addr); end
        if (int_rd_addr !== '0)   begin errors++; $display("[TB] FAIL reset_int_rd_addr: got %0d expected 0", int_rd_addr); end
        if (int_wr_addr !== '0)   begin errors++; $display("[TB] FAIL reset_int_wr_addr: got %0d expected 0", int_wr_addr); end
        if (int_wr_data !== '0)   begin errors++; $display("[TB] FAIL reset_int_wr_data: got %0d expected 0", int_wr_data); end
        reset = 1'b0;
    endtask

    task automatic test_pixel_patterns();
        int kinds[6] = '{0, 1, 3, 4, 3, 4};
        foreach (kinds[p]) begin
            int cycles, gaps, base, bad0, nw;
            bit tmo;
            logic dbusy;
            load_pattern(kinds[p]);
            base = wr_count; bad0 = bad_wr + bad_rd;
            run_frame(1'b0, cycles, tmo, gaps, dbusy);
            nw = wr_count - base;
            checks += 7;
            if (tmo)                begin errors++; $display("[TB] FAIL pat%0d_timeout: got no done expected done", p); end
            if (cycles != FRAME_CYC) begin errors++; $display("[TB] FAIL pat%0d_cycles: got %0d expected %0d", p, cycles, FRAME_CYC); end
            if (gaps != 0)          begin errors++; $display("[TB] FAIL pat%0d_busy_gaps: got %0d expected 0", p, gaps); end
            if (dbusy !== 1'b0)     begin errors++; $display("[TB] FAIL pat%0d_busy_at_done: got %0b expected 0", p, dbusy); end
            if (nw != NPIX)         begin errors++; $display("[TB] FAIL pat%0d_write_count: got %0d expected %0d", p, nw, NPIX); end
            if (sat_flag !== exp_sat) begin errors++; $display("[TB] FAIL pat%0d_sat_flag: got %0b expected %0b", p, sat_flag, exp_sat); end
            if (bad_wr + bad_rd != bad0) begin errors++; $display("[TB] FAIL pat%0d_addr_range: got %0d bad expected 0", p, bad_wr + bad_rd - bad0); end
            for (int k = 0; k < NPIX && k < nw; k++) begin
                int idx = (base + k) % LOG_N;
                checks += 2;
                if (int'(log_addr[idx]) != k) begin errors++; $display("[TB] FAIL pat%0d_wr_addr[%0d]: got %0d expected %0d", p, k, log_addr[idx], k); end
                if (log_data[idx] !== exp_val[k]) begin errors++; $display("[TB] FAIL pat%0d_wr_data[%0d]: got %0d expected %0d", p, k, log_data[idx], exp_val[k]); end
                if (k > 0) begin
                    int gap = log_time[idx] - log_time[(base + k - 1) % LOG_N];
                    checks++;
                    if (gap != PIX_CYC) begin errors++; $display("[TB] FAIL pat%0d_pixel_period[%0d]: got %0d expected %0d", p, k, gap, PIX_CYC); end
                end
            end
            if (kinds[p] == 0) begin
                checks++;
                if (int_mem[15] !== 9'd16) begin errors++; $display("[TB] FAIL ones_addr15: got %0d expected 16", int_mem[15]); end
            end
            if (kinds[p] == 1) begin
                checks += 2;
                if (int_mem[15] !== 9'd120) begin errors++; $display("[TB] FAIL ramp_addr15: got %0d expected 120", int_mem[15]); end
                if (int_mem[3] !== 9'd6)    begin errors++; $display("[TB] FAIL ramp_addr3: got %0d expected 6", int_mem[3]); end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("[TB] FAIL pat%0d_done_pulse: got %0b expected 0", p, done); end
        end
    endtask

    task automatic test_saturation();
        int cycles, gaps;
        bit tmo;
        logic dbusy;
        logic [SUM_W-1:0] exp2;
        logic exp_flag;
`ifdef INTEGRAL_SAT_EN
        exp2 = 9'd511; exp_flag = 1'b1;
`else
        exp2 = 9'd253; exp_flag = 1'b0;
`endif
        load_pattern(2);
        run_frame(1'b0, cycles, tmo, gaps, dbusy);
        checks += 3;
        if (tmo)                 begin errors++; $display("[TB] FAIL sat_timeout: got no done expected done"); end
        if (int_mem[2] !== exp2) begin errors++; $display("[TB] FAIL sat_addr2: got %0d expected %0d", int_mem[2], exp2); end
        if (sat_flag !== exp_flag) begin errors++; $display("[TB] FAIL sat_flag: got %0b expected %0b", sat_flag, exp_flag); end
        repeat (5) @(negedge clk);
        checks++;
        if (sat_flag !== exp_flag) begin errors++; $display("[TB] FAIL sat_sticky: got %0b expected %0b", sat_flag, exp_flag); end
        load_pattern(4);
        run_frame(1'b0, cycles, tmo, gaps, dbusy);
        checks += 2;
        if (sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL sat_cleared: got %0b expected 0", sat_flag); end
        if (int_mem[15] !== exp_val[15]) begin errors++; $display("[TB] FAIL sat_next_frame: got %0d expected %0d", int_mem[15], exp_val[15]); end
    endtask

    task automatic test_start_held();
        int cycles, gaps, base;
        bit tmo;
        logic dbusy;
        load_pattern(0);
        base = wr_count;
        run_frame(1'b1, cycles, tmo, gaps, dbusy);
        checks += 2;
        if (cycles != FRAME_CYC)     begin errors++; $display("[TB] FAIL held_cycles: got %0d expected %0d", cycles, FRAME_CYC); end
        if (wr_count - base != NPIX) begin errors++; $display("[TB] FAIL held_writes: got %0d expected %0d", wr_count - base, NPIX); end
        repeat (8) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL held_idle_busy: got %0b expected 0", busy); end
        if (wr_count - base != NPIX) begin errors++; $display("[TB] FAIL held_no_second: got %0d expected %0d", wr_count - base, NPIX); end
    endtask

    task automatic test_start_on_done();
        int cycles, gaps, base;
        bit tmo;
        logic dbusy;
        load_pattern(4);
        run_frame(1'b0, cycles, tmo, gaps, dbusy);
        start = 1'b1;
        base = wr_count;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL start_on_done_busy: got %0b expected 0", busy); end
        if (wr_count != base)  begin errors++; $display("[TB] FAIL start_on_done_writes: got %0d expected 0", wr_count - base); end
    endtask

    task automatic test_back_to_back();
        int cycles, gaps;
        bit tmo;
        logic dbusy;
        load_pattern(3);
        run_frame(1'b0, cycles, tmo, gaps, dbusy);
        load_pattern(1);
        run_frame(1'b0, cycles, tmo, gaps, dbusy);
        checks += 2;
        if (cycles != FRAME_CYC) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d expected %0d", cycles, FRAME_CYC); end
        if (int_mem[15] !== exp_val[15]) begin errors++; $display("[TB] FAIL b2b_addr15: got %0d expected %0d", int_mem[15], exp_val[15]); end
    endtask

    task automatic test_reset_mid_frame();
        int cycles, gaps, base, n;
        bit tmo, found;
        logic dbusy;
        load_pattern(1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < FRAME_CYC) begin
            if (int_wr_en && int'(int_wr_addr) == 7) found = 1'b1;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL midreset_reach_px7: got no write expected write"); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = wr_count;
        checks += 3;
        if (int_wr_en !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_wr_en: got %0b expected 0", int_wr_en); end
        if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL midreset_busy: got %0b expected 0", busy); end
        if (src_rd_addr !== '0)  begin errors++; $display("[TB] FAIL midreset_src_addr: got %0d expected 0", src_rd_addr); end
        repeat (10) @(negedge clk);
        checks++;
        if (wr_count != base) begin errors++; $display("[TB] FAIL midreset_no_write: got %0d expected 0", wr_count - base); end
        load_pattern(3);
        base = wr_count;
        run_frame(1'b0, cycles, tmo, gaps, dbusy);
        checks += 2;
        if (tmo) begin errors++; $display("[TB] FAIL midreset_restart_timeout: got no done expected done"); end
        if (log_addr[base % LOG_N] !== '0) begin errors++; $display("[TB] FAIL midreset_first_addr: got %0d expected 0", log_addr[base % LOG_N]); end
        for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (int_mem[k] !== exp_val[k]) begin errors++; $display("[TB] FAIL midreset_data[%0d]: got %0d expected %0d", k, int_mem[k], exp_val[k]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        $display("[TB] integral_image_engine %0dx%0d RD_LAT=%0d", IMG_W, IMG_H, RD_LAT);
        test_reset();
        test_pixel_patterns();
        test_saturation();
        test_start_held();
        test_start_on_done();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/integral_image_engine.md
INTEGRAL_IMAGE_ENGINE -- requirements
Module: integral_image_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 320: image width in pixels (>=2).
REQ-002 SHALL have parameter IMG_H, default 240: image height in rows (>=2).
REQ-003 SHALL have parameter PIX_W, default 8: unsigned source pixel width.
REQ-004 SHALL have parameter SUM_W, default 25: integral word width (>=PIX_W).
REQ-005 SHALL have parameter ADDR_W, default 17: memory address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-006 SHALL have parameter RD_LAT, default 1: memory read latency in cycles (1..3).
REQ-007 SHALL have port clk, input, 1: single clock; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-009 SHALL have port start, input, 1: frame request, sampled only in IDLE.
REQ-010 SHALL have port busy, output, 1: high from the cycle after start is accepted until DONE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at frame completion.
REQ-012 SHALL have ports src_rd_addr, output, ADDR_W, and src_rd_data, input, PIX_W: source memory read.
REQ-013 SHALL have ports int_rd_addr, output, ADDR_W, and int_rd_data, input, SUM_W: integral memory read (row above).
REQ-014 SHALL have ports int_wr_addr, output, ADDR_W; int_wr_data, output, SUM_W; int_wr_en, output, 1: integral memory write.
REQ-015 SHALL have port sat_flag, output, 1: sticky overflow indicator (see Configuration).

Function
REQ-016 SHALL compute I(r,c) = sum of src(r',c') over r'<=r, c'<=c, at linear address r*IMG_W+c, row-major.
REQ-017 SHALL use FSM states IDLE, REQ, WAIT, ACC, WRITE, DONE.
REQ-018 IDLE: start=1 -> REQ with row=0, col=0, row_acc=0; start=0 -> stay.
REQ-019 REQ: drive src_rd_addr=r*IMG_W+c; if r>0, drive int_rd_addr=(r-1)*IMG_W+c, else int_rd_addr unchanged; -> WAIT.
REQ-020 WAIT: remain exactly RD_LAT cycles; -> ACC.
REQ-021 ACC: row_acc <= row_acc+src_rd_data; sum <= row_acc+src_rd_data+(r>0 ? int_rd_data : 0); -> WRITE.
REQ-022 WRITE: int_wr_en=1 for exactly one cycle, int_wr_addr=r*IMG_W+c, int_wr_data=sum; -> REQ, or DONE after pixel (IMG_H-1, IMG_W-1).
REQ-023 Index advance in WRITE: c<IMG_W-1 -> c+1; else c=0, row_acc=0, r+1; no address beyond IMG_W*IMG_H-1 ever issued.
REQ-024 DONE: done=1 for one cycle, busy=0 in the same cycle; -> IDLE.
REQ-025 Throughput SHALL be exactly RD_LAT+3 cycles per pixel; frame = IMG_W*IMG_H*(RD_LAT+3)+1 cycles from accepted start to done.
REQ-026 start while busy SHALL be ignored; start in the same cycle as done SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-027 row_acc width SHALL be SUM_W; all additions unsigned, zero-extended to SUM_W.
REQ-028 int_wr_en SHALL be 0 in every state except WRITE.

Reset
REQ-029 On reset: state=IDLE, busy=0, done=0, int_wr_en=0, sat_flag=0, all address/data outputs=0, row=col=row_acc=sum=0.
REQ-030 Reset mid-frame SHALL abort; no write occurs from the cycle after the reset edge; the next start restarts at pixel (0,0).

Configuration
REQ-031 Macro INTEGRAL_SAT_EN: defined -> any addition exceeding 2^SUM_W-1 SHALL clamp to 2^SUM_W-1 (row_acc and sum), and set sat_flag.
REQ-032 INTEGRAL_SAT_EN undefined -> additions SHALL wrap modulo 2^SUM_W and sat_flag SHALL be tied 0.
REQ-033 sat_flag SHALL be sticky until reset or next accepted start.

Verification
REQ-034 IMG_W=IMG_H=4, RD_LAT=1, all pixels 1, start -> addr 0..15 written = (r+1)*(c+1); addr 15 = 16; done after 65 cycles.
REQ-035 Same, RD_LAT=2, pixel = linear address -> addr 15 = 120, addr 3 = 6; exactly 16 int_wr_en pulses, 81 cycles.
REQ-036 start held high throughout frame -> exactly one frame, second frame begins only on start after done.
REQ-037 reset asserted at pixel 7 write -> no int_wr_en afterwards; new start rewrites from addr 0 with correct values.
REQ-038 PIX_W=8, SUM_W=9, 4x4 all 255 -> addr 2 = 511, sat_flag=1 with INTEGRAL_SAT_EN; addr 2 = 253, sat_flag=0 without.
